fios_res_collector: RTL

Word-serial result collector and final reducer for the Montgomery FIOS multiplier. It sits downstream of the multiplier's `RES_o` word stream, LSW first. It assembles the s+1 result words of T = a·b·R⁻¹ mod p (0 ≤ T < 2p) into a parallel vector, performing the conditional final subtraction T−p on the fly. It presents the fully reduced product with a one-cycle completion pulse.

---
 rtl/fios_res_collector_pkg.sv | 17 +
 rtl/fios_word_sub.sv | 21 ++
 rtl/fios_res_collector.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/fios_res_collector_pkg.sv
// Shared types and helpers for the FIOS result collector.
package fios_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DONE
    } state_t;

    localparam int unsigned DEFAULT_S = 8;

    // Counter must be able to hold the index of the last result word (s).
    function automatic int unsigned cntWidth(input int unsigned numWords);
        return $clog2(numWords + 1);
    endfunction

endpackage

// File: rtl/fios_word_sub.sv
// One word of the final subtraction T - p: difference plus borrow chain.
module fios_word_sub
    import fios_pkg::*;
#(
    parameter int WORD_WIDTH = 17
) (
    input  logic [WORD_WIDTH-1:0] a_i,
    input  logic [WORD_WIDTH-1:0] b_i,
    input  logic                  bin_i,
    output logic [WORD_WIDTH-1:0] d_o,
    output logic                  bout_o
);

    logic [WORD_WIDTH:0] diff;

    // The extra top bit goes to 1 exactly when a_i < b_i + bin_i.
    assign diff   = {1'b0, a_i} - {1'b0, b_i} - {{WORD_WIDTH{1'b0}}, bin_i};
    assign d_o    = diff[WORD_WIDTH-1:0];
    assign bout_o = diff[WORD_WIDTH];

endmodule

// File: rtl/fios_res_collector.sv
// Collects the s+1 LSW-first FIOS result words and emits the reduced product.
// Define FIOS_FINAL_SUB_EN to build the on-the-fly conditional T - p subtraction.
module fios_res_collector
    import fios_pkg::*;
#(
    parameter int WORD_WIDTH = 17,
    parameter int s          = DEFAULT_S
) (
    input  logic                          clock_i,
    input  logic                          reset_i,
    input  logic                          start_i,
    input  logic                          res_valid_i,
    input  logic [WORD_WIDTH-1:0]         res_i,
    input  logic [s*WORD_WIDTH-1:0]       p_i,
    output logic [(s+1)*WORD_WIDTH-1:0]   result_o,
    output logic                          done_o,
    output logic                          sub_o,
    output logic                          busy_o
);

    localparam int NW    = s + 1;
    localparam int TW    = NW * WORD_WIDTH;
    localparam int CNT_W = cntWidth(s);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(s);

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [TW-1:0]       tBuf_q;
    logic [TW-1:0]       tBuf_d;
    logic [TW-1:0]       result_q;
    logic                sub_q;
    logic                done_q;

    logic                startHit;
    logic                capture;
    logic                lastWord;
    logic [CNT_W-1:0]    wordIdx;
    logic [TW-1:0]       resultSel;
    logic                subSel;

    // A start word always restarts at index 0, whatever the current state.
    assign startHit = start_i & res_valid_i;
    assign capture  = startHit | (res_valid_i & (state_q == COLLECT));
    assign wordIdx  = startHit ? '0 : cnt_q;
    assign lastWord = capture & (wordIdx == LAST_CNT);

    always_comb begin
        tBuf_d = tBuf_q;
        for (int j = 0; j < NW; j++) begin
            if (wordIdx == CNT_W'(j)) begin
                tBuf_d[j*WORD_WIDTH +: WORD_WIDTH] = res_i;
            end
        end
    end

`ifdef FIOS_FINAL_SUB_EN
    logic                  borrow_q;
    logic [TW-1:0]         dBuf_q;
    logic [TW-1:0]         dBuf_d;
    logic [WORD_WIDTH-1:0] pWord;
    logic [WORD_WIDTH-1:0] dWord;
    logic                  borrowIn;
    logic                  borrowOut;

    // The top result word is subtracted against an implicit zero modulus word.
    always_comb begin
        pWord = '0;
        for (int j = 0; j < s; j++) begin
            if (wordIdx == CNT_W'(j)) begin
                pWord = p_i[j*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

    assign borrowIn = (wordIdx == '0) ? 1'b0 : borrow_q;

    fios_word_sub #(
        .WORD_WIDTH(WORD_WIDTH)
    ) u_word_sub (
        .a_i    (res_i),
        .b_i    (pWord),
        .bin_i  (borrowIn),
        .d_o    (dWord),
        .bout_o (borrowOut)
    );

    always_comb begin
        dBuf_d = dBuf_q;
        for (int j = 0; j < NW; j++) begin
            if (wordIdx == CNT_W'(j)) begin
                dBuf_d[j*WORD_WIDTH +: WORD_WIDTH] = dWord;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            borrow_q <= 1'b0;
            dBuf_q   <= '0;
        end else if (capture) begin
            borrow_q <= borrowOut;
            dBuf_q   <= dBuf_d;
        end
    end

    // A final borrow means T < p, so the raw value is already reduced.
    assign resultSel = borrowOut ? tBuf_d : dBuf_d;
    assign subSel    = ~borrowOut;
`else
    logic unusedModulus;

    assign unusedModulus = ^p_i;
    assign resultSel     = tBuf_d;
    assign subSel        = 1'b0;
`endif

    // Result and flag are loaded on the edge that captures the last word,
    // so they appear together with the DONE pulse.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            tBuf_q   <= '0;
            result_q <= '0;
            sub_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (capture) begin
                tBuf_q <= tBuf_d;
            end
            if (startHit) begin
                state_q <= COLLECT;
                cnt_q   <= CNT_W'(1);
            end else begin
                case (state_q)
                    COLLECT: begin
                        if (res_valid_i) begin
                            if (lastWord) begin
                                state_q  <= DONE;
                                cnt_q    <= '0;
                                done_q   <= 1'b1;
                                result_q <= resultSel;
                                sub_q    <= subSel;
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign result_o = result_q;
    assign sub_o    = sub_q;
    assign done_o   = done_q;
    assign busy_o   = (state_q == COLLECT);

endmodule
